// File: rtl/inst_loader.sv
// inst_loader: assembles a high-byte-first byte stream into 16-bit instruction-store writes.
// Optional INST_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and the err flag.
module inst_loader #(
  parameter int ADDR_W = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE, CHK} state_t;
`else
  typedef enum logic [2:0] {IDLE, HI, LO, WRITE, DONE} state_t;
`endif
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  state_t state, nxt;
  logic [ADDR_W:0] cnt;
  logic xfer, last, in_chk;
  assign xfer = rx_valid && rx_ready;
  assign last = cnt[ADDR_W:1] == '0;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = start ? (num_words == '0 ? DONE : HI) : IDLE;
      HI:    nxt = xfer ? LO : HI;
      LO:    nxt = xfer ? WRITE : LO;
`ifdef INST_LOADER_CHECKSUM_EN
      WRITE: nxt = last ? CHK : HI;
      CHK:   nxt = xfer ? DONE : CHK;
`else
      WRITE: nxt = last ? DONE : HI;
`endif
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
`ifdef INST_LOADER_CHECKSUM_EN
  assign in_chk = state == CHK;
`else
  assign in_chk = 1'b0;
`endif
  always_comb begin
    rx_ready = state == HI || state == LO || in_chk;
    wr_en    = state == WRITE;
    busy     = state == HI || state == LO || state == WRITE || in_chk;
    cpu_hold = state != IDLE;
    done     = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr <= BASE;
      wr_data <= '0;
      cnt     <= '0;
    end else if (state == IDLE && start) begin
      wr_addr <= BASE;
      cnt     <= num_words;
    end else if (state == HI && xfer) begin
      wr_data[15:8] <= rx_data;
    end else if (state == LO && xfer) begin
      wr_data[7:0] <= rx_data;
    end else if (state == WRITE) begin
      wr_addr <= wr_addr + 1'b1;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else if (state == IDLE && start) begin
      csum <= '0;
      err  <= 1'b0;
    end else if ((state == HI || state == LO) && xfer) begin
      csum <= csum ^ rx_data;
    end else if (in_chk && xfer) begin
      err <= rx_data != csum;
    end
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Writer side of the instruction memory: receives a byte stream over a valid/ready handshake and assembles 16-bit instructions, high byte first.
- Writes each instruction into the instruction store at consecutive addresses.
- Holds the core stalled while loading, then pulses done.
- Replaces fixed initial-block program contents with a runtime load path, e.g. from a UART receiver.

Parameters:
- ADDR_W, 8, instruction address width; 256-entry store.
- BASE_ADDR, 0, first write address of every load.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request to begin a load; sampled only in IDLE
- num_words  input  ADDR_W+1  number of 16-bit words to load, 0..256; sampled with start
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader accepts byte this cycle
- wr_en  output  1  instruction-store write strobe, one cycle per word
- wr_addr  output  ADDR_W  write address
- wr_data  output  16  write data {high byte, low byte}
- busy  output  1  load in progress
- cpu_hold  output  1  stall request to core/PC
- done  output  1  one-cycle pulse at end of load
- err  output  1  checksum mismatch flag; constant 0 without the optional feature

Behaviour:
- Reset (synchronous, any state, including mid-load):
  - State returns to IDLE.
  - rx_ready, wr_en, busy, cpu_hold, done and err are all 0.
  - wr_addr = BASE_ADDR, wr_data = 0.
  - Words already written stay in memory; the loader never erases.
- Handshake: a byte transfers on a cycle where rx_valid && rx_ready. rx_data is ignored otherwise. The producer may drop rx_valid at any time.
- All outputs are registered or pure state decodes (Moore); there is no combinational path from rx_* to outputs.
- IDLE:
  - rx_ready = 0, busy = 0, cpu_hold = 0.
  - start && num_words != 0: latch the count, wr_addr <= BASE_ADDR, go to HI.
  - start && num_words == 0: go to DONE with no write.
- HI: rx_ready = 1; on transfer, latch the high byte and go to LO.
- LO: rx_ready = 1; on transfer, latch the low byte and go to WRITE.
- WRITE:
  - rx_ready = 0, wr_en = 1 for exactly this cycle, presenting current wr_addr/wr_data.
  - On exit: wr_addr increments modulo 2^ADDR_W (0xFF wraps to 0x00) and the remaining count decrements.
  - Goes to DONE if this was the last word (or CHK when the optional feature is enabled); otherwise to HI.
- DONE: done = 1 for one cycle, then IDLE.
- busy = 1 in HI, LO, WRITE and CHK. cpu_hold = 1 in every state except IDLE, including DONE.
- start outside IDLE is ignored and num_words is not re-sampled.
- Minimum 3 cycles per word: 2 byte cycles plus 1 write cycle.
- A 256-word load from BASE_ADDR 0 ends with wr_addr back at 0x00.
- The remaining-word counter never underflows.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- When defined:
  - After the last WRITE, the FSM enters CHK with rx_ready = 1 and accepts one extra byte.
  - If that byte != XOR of all data bytes of the load, err <= 1; then go to DONE.
  - err is cleared on the next accepted start and by rst.
  - A num_words == 0 load skips CHK and leaves err = 0.
- When undefined: no CHK state, err is tied 0, and WRITE of the last word goes straight to DONE.

Test Plan:
- Basic load: BASE_ADDR = 0, start with num_words = 3, bytes 41 00 42 02 03 21 with rx_valid held 1.
  - Required: wr_en pulses with (0x00, 0x4100), (0x01, 0x4202), (0x02, 0x0321), 3 cycles apart.
  - Then done = 1 for one cycle and cpu_hold drops the cycle after.
- Wrap-around: BASE_ADDR = 0xFE, num_words = 3, bytes 11 11 22 22 33 33.
  - Required: writes at 0xFE, 0xFF, 0x00 with data 0x1111, 0x2222, 0x3333.
- Backpressure: num_words = 1 with rx_valid low for 5 cycles between byte 0xAB and byte 0xCD.
  - Required: a single write of 0xABCD.
  - No wr_en before the second byte; rx_ready stays 1 throughout the gap.
- Zero and ignored start: num_words = 0 gives done the cycle after start with no wr_en. A start pulse with num_words = 5 in the middle of a 2-word load is ignored: exactly 2 writes occur.
- Reset mid-load: rst asserted in state LO after 1 word has been written.
  - Required next cycle: all outputs at reset values and the FSM in IDLE.
  - A new 1-word load then writes to BASE_ADDR.
- With INST_LOADER_CHECKSUM_EN: bytes 41 00 42 02 then checksum 0x01 gives err = 0 with done. Checksum 0x00 gives err = 1, held until the next start.
